// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive controller slice.
//   rx_state_e     : receiver FSM state encoding
//   DATA_BITS_DEF  : default payload width (bits per frame, LSB first)
//   OVERSAMPLE_DEF : default number of baud_tick pulses per bit period
//   MID_SAMPLE     : tick index at which the start bit is re-checked
//   mid_sample()   : same index for an arbitrary oversample ratio
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    localparam int DATA_BITS_DEF  = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Half a bit period after the falling edge, counted from zero.
    function automatic int mid_sample(input int oversample);
        return oversample / 2 - 1;
    endfunction

    localparam int MID_SAMPLE = mid_sample(OVERSAMPLE_DEF);

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Bundles the serial input, tick enable, parity-checker handshake and the
// received-frame outputs of uart_rx_ctrl.
//   master : line/tick/checker side (drives rx_in, baud_tick, parity_error)
//   slave  : the receiver (drives payload, parity and status outputs)
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 rx_in;
    logic                 baud_tick;
    logic                 parity_error;
    logic [DATA_BITS-1:0] data_received;
    logic                 parity_bit_rx;
    logic                 parity_load;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 par_err;
    logic                 busy;

    modport master (
        output rx_in, baud_tick, parity_error,
        input  data_received, parity_bit_rx, parity_load,
               rx_valid, frame_err, par_err, busy
    );

    modport slave (
        input  rx_in, baud_tick, parity_error,
        output data_received, parity_bit_rx, parity_load,
               rx_valid, frame_err, par_err, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value. Everything resets to the idle (high)
// level so no edge is reported out of reset.
//   clk     : system clock
//   rst     : synchronous, active-high reset
//   rx_in   : asynchronous serial line, idle high
//   rx_sync : synchronized line level
//   rx_fall : one-cycle pulse when rx_sync goes from high to low
// ---------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_sync,
    output logic rx_fall
);
    logic [1:0] sync_q;
    logic       prev_q;

    // NOTE: reset is sampled inside the clocked block, so it is synchronous
    // and only takes effect on the next rising edge of clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old
            // value of its neighbour, which is what makes this a shift chain.
            sync_q <= {sync_q[0], rx_in};
            prev_q <= sync_q[1];
        end
    end

    assign rx_sync = sync_q[1];
    assign rx_fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Oversampling UART receiver: start-bit validation, LSB-first payload
// assembly, optional parity sampling with an external checker, and stop-bit
// checking with one-cycle result pulses.
//   clk   : system clock, all state updates on the rising edge
//   rst   : synchronous, active-high reset
//   bus   : uart_rx_ctrl_if.slave
//           in : rx_in, baud_tick, parity_error
//           out: data_received, parity_bit_rx, parity_load,
//                rx_valid, frame_err, par_err, busy
// Configuration macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the payload; parity_load enables the
//               external checker and its verdict is reported on par_err.
//   undefined : the stop bit follows the payload directly; parity_load,
//               parity_bit_rx and par_err are held at 0.
// ---------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(mid_sample(OVERSAMPLE));
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = RX_IDLE;
    localparam logic [2:0] S_START  = RX_START;
    localparam logic [2:0] S_DATA   = RX_DATA;
    localparam logic [2:0] S_STOP   = RX_STOP;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = RX_PARITY;
`endif

    logic                 rx_sync;
    logic                 rx_fall;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] data_q;
    logic                 fall_pend;
    logic                 rx_valid_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q;
    logic                 par_load_q;
    logic                 par_load_d1;
    logic                 par_err_lat;
    logic                 par_err_q;
`endif

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx_in   (bus.rx_in),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    // FSM, tick/bit counters and the payload shift register. The payload is
    // shifted straight into the output register, so the previous frame stays
    // visible until the first data sample of the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            data_q      <= '0;
            fall_pend   <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= 1'b0;
            par_load_q  <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: result flags are given a default every cycle so they are
            // one-cycle pulses; only the stop-bit branch overrides them.
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    tick_cnt  <= '0;
                    bit_cnt   <= '0;
                    fall_pend <= 1'b0;
                    if (rx_fall || fall_pend) begin
                        state <= S_START;
                    end
                end

                // Re-check the line half a bit in; a high line was a glitch.
                S_START: begin
                    if (bus.baud_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            state    <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                S_DATA: begin
                    if (bus.baud_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            data_q   <= {rx_sync, data_q[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= S_PARITY;
`else
                                state   <= S_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bus.baud_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt   <= '0;
                            par_bit_q  <= rx_sync;
                            par_load_q <= 1'b1;
                            state      <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif

                S_STOP: begin
                    // The next start bit may begin before the stop sample is
                    // taken; remember it so IDLE can leave on the next cycle.
                    if (rx_fall) begin
                        fall_pend <= 1'b1;
                    end
                    if (bus.baud_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt    <= '0;
                            rx_valid_q  <= rx_sync;
                            frame_err_q <= ~rx_sync;
`ifdef UART_RX_PARITY_EN
                            par_err_q   <= par_err_lat;
                            par_load_q  <= 1'b0;
`endif
                            state       <= S_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // The checker's verdict is valid from the second cycle parity_load is
    // high; keep sampling it while the load stays up and clear it per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_load_d1 <= 1'b0;
            par_err_lat <= 1'b0;
        end else begin
            par_load_d1 <= par_load_q;
            if (state == S_START) begin
                par_err_lat <= 1'b0;
            end else if (par_load_q && par_load_d1) begin
                par_err_lat <= bus.parity_error;
            end
        end
    end

    assign bus.parity_bit_rx = par_bit_q;
    assign bus.parity_load   = par_load_q;
    assign bus.par_err       = par_err_q;
`else
    logic unused_parity_error;
    assign unused_parity_error = bus.parity_error;

    assign bus.parity_bit_rx = 1'b0;
    assign bus.parity_load   = 1'b0;
    assign bus.par_err       = 1'b0;
`endif

    assign bus.data_received = data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.busy          = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl (DATA_BITS=8, OVERSAMPLE=16, one baud_tick
// every TICK_DIV clocks). A table of frames with hand-computed results is
// replayed in a loop, followed by hand-written glitch, mid-frame reset and
// back-to-back sequences. Works with and without UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int TICK_DIV = 2;
    localparam int BIT_CYC  = OVERSAMPLE_DEF * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Tick generator and even-parity checker model.
    initial begin
        int div;
        div = 0;
        bus.baud_tick    = 1'b0;
        bus.parity_error = 1'b0;
        forever begin
            @(negedge clk);
            bus.baud_tick    = (div == 0);
            div              = (div + 1) % TICK_DIV;
            bus.parity_error = bus.parity_load & (^{bus.data_received, bus.parity_bit_rx});
        end
    end

    // Pulse monitor.
    int         n_valid   = 0;
    int         n_ferr    = 0;
    int         n_perr    = 0;
    int         n_stray   = 0;
    int         n_busy_bad = 0;
    bit         load_seen = 1'b0;
    bit         last_pulse = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (last_pulse && bus.busy === 1'b1) n_busy_bad++;
        last_pulse = (bus.rx_valid === 1'b1) || (bus.frame_err === 1'b1);
        if (bus.rx_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(bus.data_received);
        end
        if (bus.frame_err === 1'b1) n_ferr++;
        if (bus.par_err === 1'b1) begin
            if (last_pulse) n_perr++;
            else            n_stray++;
        end
        if (bus.parity_load === 1'b1) load_seen = 1'b1;
    end

    task automatic drive_bit(input logic b);
        bus.rx_in = b;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(p);
        drive_bit(stop);
        bus.rx_in = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        int   bv, bf, bp, bb, qb;

        // data, parity bit (even), stop, valid, ferr, perr, data out
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 0, 0,           8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1, 0, int'(PAR_EN), 8'h3C};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 0, 1, 0,           8'h55};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1, 0, 0,           8'h00};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1, 0, 0,           8'hFF};

        rst       = 1'b1;
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset data_received", bus.data_received, 8'h00);
        check("reset busy",          bus.busy,          1'b0);
        check("reset rx_valid",      bus.rx_valid,      1'b0);
        check("reset frame_err",     bus.frame_err,     1'b0);
        check("reset par_err",       bus.par_err,       1'b0);
        check("reset parity_load",   bus.parity_load,   1'b0);
        check("reset parity_bit_rx", bus.parity_bit_rx, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            bv = n_valid; bf = n_ferr; bp = n_perr; bb = n_busy_bad;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            repeat (BIT_CYC) @(negedge clk);
            check($sformatf("row%0d rx_valid count", i),  n_valid - bv,      vecs[i].exp_valid);
            check($sformatf("row%0d frame_err count", i), n_ferr - bf,       vecs[i].exp_ferr);
            check($sformatf("row%0d par_err count", i),   n_perr - bp,       vecs[i].exp_perr);
            check($sformatf("row%0d data", i),            bus.data_received, vecs[i].exp_data);
            check($sformatf("row%0d busy after", i),      n_busy_bad - bb,   0);
            check($sformatf("row%0d busy idle", i),       bus.busy,          1'b0);
        end

        // Four-tick low glitch on an idle line.
        bv = n_valid; bf = n_ferr;
        bus.rx_in = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        check("glitch busy during", bus.busy, 1'b1);
        bus.rx_in = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        check("glitch busy after",  bus.busy,          1'b0);
        check("glitch rx_valid",    n_valid - bv,      0);
        check("glitch frame_err",   n_ferr - bf,       0);
        check("glitch data held",   bus.data_received, 8'hFF);

        // Reset during data bit 3 of 0xFF, then a clean 0x81.
        bv = n_valid; bf = n_ferr;
        bus.rx_in = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        bus.rx_in = 1'b1;
        repeat (3 * BIT_CYC + 8) @(negedge clk);
        check("midreset busy before", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset data",        bus.data_received, 8'h00);
        check("midreset busy",        bus.busy,          1'b0);
        check("midreset parity_load", bus.parity_load,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7 * BIT_CYC) @(negedge clk);
        check("midreset no rx_valid",  n_valid - bv, 0);
        check("midreset no frame_err", n_ferr - bf,  0);
        qb = got_q.size();
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (BIT_CYC) @(negedge clk);
        check("after reset rx_valid count", n_valid - bv, 1);
        check("after reset frame data", (got_q.size() > qb) ? got_q[qb] : 8'hxx, 8'h81);

        // Back-to-back frames with no idle gap.
        bv = n_valid; bf = n_ferr; qb = got_q.size();
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        repeat (BIT_CYC) @(negedge clk);
        check("b2b rx_valid count", n_valid - bv, 2);
        check("b2b frame_err",      n_ferr - bf,  0);
        check("b2b first data",  (got_q.size() > qb)     ? got_q[qb]     : 8'hxx, 8'h01);
        check("b2b second data", (got_q.size() > qb + 1) ? got_q[qb + 1] : 8'hxx, 8'h80);
        check("parity_load seen", load_seen, PAR_EN);
        check("stray par_err",    n_stray,   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
